// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and segment patterns for the seven-segment scan driver
// Patterns are active high with seg[0]=a through seg[6]=g.
package seg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to seven-segment decoder
// Ports: bcd (in, one BCD digit), seg (out, active-high pattern).
// Codes 10..15 are not valid BCD and show a dash so a corrupted counter is visible.
module bcd_to_seg
  import seg_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed seven-segment scan driver with per-frame snapshot
// Ports: clk, rst (sync, active high), en (scan enable), d (packed BCD, d[0] = LSD),
//        dp_mask (decimal point per digit), blank_lz (leading-zero blanking),
//        an (one-hot digit enable), seg (a..g), dp (active digit point),
//        frame_start (one-cycle pulse on each snapshot load).
module seg_scan
  import seg_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int SCAN_DIV   = 1000,
  parameter int GUARD      = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_DIGITS-1:0][3:0] d,
  input  logic [N_DIGITS-1:0]      dp_mask,
  input  logic                     blank_lz,
  output logic [N_DIGITS-1:0]      an,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic                     frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            idx;
  bcd_t [N_DIGITS-1:0]      snap_d;
  logic [N_DIGITS-1:0]      snap_dp;
  logic                     load_pend;

  logic                     slot_end;
  logic                     wrap;
  logic                     load_now;
  logic                     lit;
  bcd_t                     cur_d;
  seg_t                     cur_seg;
  logic                     lz_run;
  logic [N_DIGITS-1:0]      lz_blank;
  logic [N_DIGITS-1:0]      an_c;
  seg_t                     seg_c;
  logic                     dp_c;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  // Reset leaves a load pending so the first enabled cycle shows fresh digits
  // instead of waiting a whole frame.
  assign load_now = load_pend || wrap;
  assign lit      = en && (cnt >= CNT_GUARD);
  assign cur_d    = snap_d[idx];

  bcd_to_seg u_dec (
    .bcd (cur_d),
    .seg (cur_seg)
  );

  // Walk from the MSB down; a digit is blankable while every digit at or above
  // it is zero. Digit 0 is left out so a zero value still shows "0".
  always_comb begin
    lz_run   = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run && (snap_d[i] == 4'd0);
      lz_blank[i] = lz_run;
    end
  end

  always_comb begin
    an_c  = '0;
    seg_c = SEG_OFF;
    dp_c  = 1'b0;
    if (lit) begin
      an_c[idx] = 1'b1;
      if (!(blank_lz && lz_blank[idx])) begin
        seg_c = cur_seg;
        dp_c  = snap_dp[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      snap_d      <= '0;
      snap_dp     <= '0;
      load_pend   <= 1'b1;
      frame_start <= 1'b0;
      an          <= {N_DIGITS{POL}};
      seg         <= {7{POL}};
      dp          <= POL;
    end else begin
      frame_start <= en && load_now;
      an          <= an_c ^ {N_DIGITS{POL}};
      seg         <= seg_c ^ {7{POL}};
      dp          <= dp_c ^ POL;
      if (en) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (load_now) begin
          snap_d    <= d;
          snap_dp   <= dp_mask;
          load_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan, both output polarities
module tb_seg_scan;

  typedef struct packed {
    logic       fs;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  // Per-digit patterns, digit 5 first, digit 0 last.
  localparam logic [41:0] P123456 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
  localparam logic [41:0] P127459 = {7'h06, 7'h5B, 7'h07, 7'h66, 7'h6D, 7'h6F};
  localparam logic [41:0] P000007 = {35'h0, 7'h07};
  localparam logic [41:0] P000000 = {35'h0, 7'h3F};
  localparam logic [41:0] P12345A = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h40};

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [5:0][3:0] d;
  logic [5:0]      dp_mask;
  logic            blank_lz;
  logic [5:0]      an0, an1;
  logic [6:0]      seg0, seg1;
  logic            dp0, dp1, fs0, fs1;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;

  always #5 clk = ~clk;

  seg_scan #(.N_DIGITS(6), .SCAN_DIV(4), .GUARD(1), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .d(d), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .an(an0), .seg(seg0), .dp(dp0), .frame_start(fs0)
  );

  seg_scan #(.N_DIGITS(6), .SCAN_DIV(4), .GUARD(1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .d(d), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .an(an1), .seg(seg1), .dp(dp1), .frame_start(fs1)
  );

  // Monitor: one expected entry per clock, compared just after the edge.
  always @(posedge clk) begin
    #1;
    ncyc++;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      checks++;
      if ({fs0, an0, seg0, dp0} !== mon_e) begin
        errors++;
        $display("FAIL cyc%0d al0 got fs=%b an=%b seg=%h dp=%b exp fs=%b an=%b seg=%h dp=%b",
                 ncyc, fs0, an0, seg0, dp0, mon_e.fs, mon_e.an, mon_e.seg, mon_e.dp);
      end
      checks++;
      if ({fs1, an1, seg1, dp1} !== {mon_e.fs, ~mon_e.an, ~mon_e.seg, ~mon_e.dp}) begin
        errors++;
        $display("FAIL cyc%0d al1 got fs=%b an=%b seg=%h dp=%b exp fs=%b an=%b seg=%h dp=%b",
                 ncyc, fs1, an1, seg1, dp1, mon_e.fs, ~mon_e.an, ~mon_e.seg, ~mon_e.dp);
      end
    end
  end

  task automatic cyc(input logic fs, input logic [5:0] a, input logic [6:0] s, input logic p);
    expq.push_back({fs, a, s, p});
    @(negedge clk);
  endtask

  // One 24-cycle frame. Optional events at frame cycle c: input change,
  // a 10-cycle enable drop, or a 1-cycle reset that aborts the frame.
  task automatic run_frame(input logic [41:0] pat, input logic [5:0] dpv, input bit fs_first,
                           input int chg_c, input logic [23:0] nd, input logic [5:0] ndp,
                           input logic nblz, input int drop_c, input int rst_c);
    int i;
    int k;
    for (int c = 0; c < 24; c++) begin
      if (c == chg_c) begin
        d        = nd;
        dp_mask  = ndp;
        blank_lz = nblz;
      end
      if (c == rst_c) begin
        rst = 1'b1;
        cyc(1'b0, 6'b0, 7'h00, 1'b0);
        rst = 1'b0;
        return;
      end
      if (c == drop_c) begin
        en = 1'b0;
        repeat (10) cyc(1'b0, 6'b0, 7'h00, 1'b0);
        en = 1'b1;
      end
      i = c / 4;
      k = c % 4;
      cyc((c == 0 && fs_first) || (c == 23),
          (k >= 1) ? (6'b1 << i) : 6'b0,
          (k >= 1) ? pat[i*7 +: 7] : 7'h00,
          (k >= 1) ? dpv[i] : 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    d        = 24'h123456;
    dp_mask  = 6'b0;
    blank_lz = 1'b0;
    repeat (2) cyc(1'b0, 6'b0, 7'h00, 1'b0);
    rst = 1'b0;
    repeat (2) cyc(1'b0, 6'b0, 7'h00, 1'b0);
    en = 1'b1;
    run_frame(P123456, 6'b0, 1'b1, -1, 24'h0, 6'b0, 1'b0, -1, -1);
    run_frame(P123456, 6'b0, 1'b0,  9, 24'h127459, 6'b0, 1'b0, -1, -1);
    run_frame(P127459, 6'b0, 1'b0,  5, 24'h000007, 6'b0, 1'b1, -1, -1);
    run_frame(P000007, 6'b0, 1'b0,  5, 24'h000000, 6'b0, 1'b1, -1, -1);
    run_frame(P000000, 6'b0, 1'b0,  5, 24'h12345A, 6'b000001, 1'b1, -1, -1);
    run_frame(P12345A, 6'b000001, 1'b0, 5, 24'h123456, 6'b0, 1'b0, -1, -1);
    run_frame(P123456, 6'b0, 1'b0, -1, 24'h0, 6'b0, 1'b0, 14, -1);
    run_frame(P123456, 6'b0, 1'b0, -1, 24'h0, 6'b0, 1'b0, -1, 18);
    run_frame(P123456, 6'b0, 1'b1, -1, 24'h0, 6'b0, 1'b0, -1, -1);
    run_frame(P123456, 6'b0, 1'b0, -1, 24'h0, 6'b0, 1'b0, -1, -1);
    for (int n = 0; n < 5 && expq.size() > 0; n++) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
